// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI flash read sequencer: register map, flash opcode, FSM states.
package spi_seq_pkg;

    localparam int unsigned APB_AW      = 5;
    localparam int unsigned APB_DW      = 32;
    localparam int unsigned FLASH_AW    = 24;
    localparam int unsigned CNT_W       = 9;
    localparam int unsigned CHAR_LEN_32 = 32;

    localparam logic [APB_AW-1:0] REG_RX0  = 5'h00;
    localparam logic [APB_AW-1:0] REG_TX0  = 5'h00;
    localparam logic [APB_AW-1:0] REG_CTRL = 5'h10;

    localparam logic [7:0] FLASH_OP_READ = 8'h03;

    typedef enum logic [3:0] {
        IDLE,
        CMD_TX,
        CMD_GO,
        CMD_WAIT,
        DAT_TX,
        DAT_GO,
        DAT_WAIT,
        DAT_RX,
        PUSH,
        DESEL
    } seq_state_t;

endpackage

// File: rtl/spi_apb_mst.sv
// Single-access APB master: one SETUP cycle, ACCESS until pready, then a one-cycle done pulse.
module spi_apb_mst
    import spi_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [APB_AW-1:0] addr,
    input  logic [APB_DW-1:0] wdata,
    input  logic              write,
    output logic              done,
    output logic [APB_DW-1:0] rdata,
    output logic              err,
    output logic [APB_AW-1:0] m_paddr,
    output logic [APB_DW-1:0] m_pwdata,
    output logic              m_psel,
    output logic              m_penable,
    output logic              m_pwrite,
    input  logic [APB_DW-1:0] m_prdata,
    input  logic              m_pready,
    input  logic              m_pslverr
);

    typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_state_t;

    apb_state_t        state_q, state_d;
    logic              psel_d, penable_d, pwrite_d, done_d, err_d;
    logic [APB_AW-1:0] paddr_d;
    logic [APB_DW-1:0] pwdata_d, rdata_d;

    // Next-state and next-output logic for the APB phases
    always_comb begin
        state_d   = state_q;
        psel_d    = m_psel;
        penable_d = m_penable;
        pwrite_d  = m_pwrite;
        paddr_d   = m_paddr;
        pwdata_d  = m_pwdata;
        rdata_d   = rdata;
        err_d     = err;
        done_d    = 1'b0;
        case (state_q)
            A_IDLE: begin
                if (start) begin
                    state_d   = A_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = write;
                    paddr_d   = addr;
                    pwdata_d  = wdata;
                end
            end
            A_SETUP: begin
                state_d   = A_ACCESS;
                penable_d = 1'b1;
            end
            A_ACCESS: begin
                if (m_pready) begin
                    state_d   = A_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = 1'b1;
                    rdata_d   = m_prdata;
                    err_d     = m_pslverr;
                end
            end
            default: state_d = A_IDLE;
        endcase
    end

    // State and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= A_IDLE;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_psel    <= psel_d;
            m_penable <= penable_d;
            m_pwrite  <= pwrite_d;
            m_paddr   <= paddr_d;
            m_pwdata  <= pwdata_d;
            rdata     <= rdata_d;
            err       <= err_d;
            done      <= done_d;
        end
    end

endmodule

// File: rtl/spi_rd_seq.sv
// SPI flash read sequencer: turns (addr, len) requests into APB accesses on an SPI controller
// and streams the received words out. Define SPI_RD_SEQ_IRQ_EN to wait on irq_i instead of polling GO.
module spi_rd_seq
    import spi_seq_pkg::*;
#(
    parameter logic [31:0] CTRL_SEL  = 32'h0000_0000,
    parameter logic [31:0] CTRL_IDLE = 32'h0000_0000,
    parameter int unsigned GO_BIT    = 8,
    parameter int unsigned IE_BIT    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_err,
    output logic        busy,
    output logic [4:0]  m_paddr,
    output logic [31:0] m_pwdata,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr,
    input  logic        irq_i
);

`ifdef SPI_RD_SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam logic [31:0] GO_WORD = CTRL_SEL | (32'd1 << GO_BIT) | 32'(CHAR_LEN_32)
                                    | (IRQ_EN ? (32'd1 << IE_BIT) : 32'd0);

    seq_state_t          state_q, state_d;
    logic                acc_pend_q, acc_pend_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FLASH_AW-1:0] addr_q, addr_d;
    logic                err_q, err_d;
    logic [31:0]         rsp_data_d;
    logic                rsp_last_d, rsp_err_d;

    logic                start_c, acc_write_c, is_acc_c, is_wait_c;
    logic [APB_AW-1:0]   acc_addr_c;
    logic [APB_DW-1:0]   acc_wdata_c;
    logic                apb_done, apb_err;
    logic [APB_DW-1:0]   apb_rdata;

    // Sequencing of APB accesses, word count and response capture
    always_comb begin
        state_d     = state_q;
        acc_pend_d  = acc_pend_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        err_d       = err_q;
        rsp_data_d  = rsp_data;
        rsp_last_d  = rsp_last;
        rsp_err_d   = rsp_err;
        start_c     = 1'b0;
        is_acc_c    = 1'b1;
        is_wait_c   = 1'b0;
        acc_write_c = 1'b0;
        acc_addr_c  = REG_CTRL;
        acc_wdata_c = '0;

        case (state_q)
            CMD_TX: begin
                acc_write_c = 1'b1;
                acc_addr_c  = REG_TX0;
                acc_wdata_c = {FLASH_OP_READ, addr_q};
            end
            CMD_GO, DAT_GO: begin
                acc_write_c = 1'b1;
                acc_wdata_c = GO_WORD;
            end
            CMD_WAIT, DAT_WAIT: is_wait_c = 1'b1;
            DAT_TX: begin
                acc_write_c = 1'b1;
                acc_addr_c  = REG_TX0;
                acc_wdata_c = 32'hFFFF_FFFF;
            end
            DAT_RX: acc_addr_c = REG_RX0;
            DESEL: begin
                acc_write_c = 1'b1;
                acc_wdata_c = CTRL_IDLE;
            end
            default: is_acc_c = 1'b0;
        endcase

        // In interrupt mode the wait states only touch the bus once irq_i is seen
        if (is_acc_c && !acc_pend_q && (!is_wait_c || !IRQ_EN || irq_i)) begin
            start_c    = 1'b1;
            acc_pend_d = 1'b1;
        end
        if (apb_done) begin
            acc_pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d    = req_addr;
                    cnt_d     = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
                    err_d     = 1'b0;
                    rsp_last_d = 1'b0;
                    rsp_err_d = 1'b0;
                    state_d   = CMD_TX;
                end
            end
            PUSH: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q - 9'd1;
                    state_d = (err_q || cnt_q == 9'd1) ? DESEL : DAT_TX;
                end
            end
            default: begin
                if (apb_done) begin
                    if (apb_err && state_q != DESEL) begin
                        err_d      = 1'b1;
                        rsp_data_d = '0;
                        rsp_last_d = 1'b1;
                        rsp_err_d  = 1'b1;
                        state_d    = PUSH;
                    end else begin
                        case (state_q)
                            CMD_TX:   state_d = CMD_GO;
                            CMD_GO:   state_d = CMD_WAIT;
                            CMD_WAIT: if (IRQ_EN || !apb_rdata[GO_BIT]) state_d = DAT_TX;
                            DAT_TX:   state_d = DAT_GO;
                            DAT_GO:   state_d = DAT_WAIT;
                            DAT_WAIT: if (IRQ_EN || !apb_rdata[GO_BIT]) state_d = DAT_RX;
                            DAT_RX: begin
                                rsp_data_d = apb_rdata;
                                rsp_last_d = (cnt_q == 9'd1);
                                rsp_err_d  = 1'b0;
                                state_d    = PUSH;
                            end
                            DESEL:    state_d = IDLE;
                            default:  state_d = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // State register and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_pend_q <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_pend_q <= acc_pend_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            req_ready  <= (state_d == IDLE);
            rsp_valid  <= (state_d == PUSH);
            rsp_data   <= rsp_data_d;
            rsp_last   <= rsp_last_d;
            rsp_err    <= rsp_err_d;
            busy       <= (state_d != IDLE);
        end
    end

    spi_apb_mst u_apb (
        .clk       (clk),
        .rst       (rst),
        .start     (start_c),
        .addr      (acc_addr_c),
        .wdata     (acc_wdata_c),
        .write     (acc_write_c),
        .done      (apb_done),
        .rdata     (apb_rdata),
        .err       (apb_err),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr)
    );

endmodule

// File: tb/tb_spi_rd_seq.sv
// Bench for spi_rd_seq: SPI controller/APB slave model, table of requests, random requests,
// stall, error and mid-transaction reset sequences. Honours SPI_RD_SEQ_IRQ_EN.
module tb_spi_rd_seq;

    localparam logic [31:0] CTRL_SEL  = 32'h0001_0004;
    localparam logic [31:0] CTRL_IDLE = 32'h0000_0004;
    localparam int          GO_BIT    = 8;
    localparam int          IE_BIT    = 12;
`ifdef SPI_RD_SEQ_IRQ_EN
    localparam bit IRQ_MODE = 1'b1;
`else
    localparam bit IRQ_MODE = 1'b0;
`endif
    localparam logic [31:0] GO_WORD = CTRL_SEL | 32'h0000_0120 | (IRQ_MODE ? 32'h0000_1000 : 32'h0);

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [23:0] req_addr;
    logic [7:0]  req_len;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last, rsp_err, busy;
    logic [4:0]  m_paddr;
    logic [31:0] m_pwdata, m_prdata;
    logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic        irq_q;

    spi_rd_seq #(
        .CTRL_SEL (CTRL_SEL),
        .CTRL_IDLE(CTRL_IDLE),
        .GO_BIT   (GO_BIT),
        .IE_BIT   (IE_BIT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .irq_i(irq_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [31:0] d; logic l; logic e; } rsp_t;

    wr_t  wr_log[$];
    rsp_t rsp_log[$];

    // Flash contents as seen through the controller
    function automatic logic [31:0] word_fn(input logic [23:0] a, input int i);
        if (a == 24'h012345 && i == 0) return 32'hA5A5_5A5A;
        return {8'(i), a} ^ 32'hC3F1_0F5A;
    endfunction

    // ---------------- SPI controller model behind an APB slave ----------------
    int          err_go = -1;
    int          busy_min = 0, busy_max = 2;
    int          wait_cnt, busy_cnt, go_wr_cnt, xfer_cnt;
    bit          go_active;
    logic [31:0] ctrl_q, rx_q;
    logic [23:0] cmd_addr;
    int          ctrl_busy_wr = 0, ctrl_rd_busy = 0;

    function automatic logic [31:0] read_val();
        if (m_paddr == 5'h10) return (ctrl_q & ~32'h0000_0100) | (go_active ? 32'h0000_0100 : 32'h0);
        return rx_q;
    endfunction

    function automatic logic inject();
        return m_pwrite && m_paddr == 5'h10 && m_pwdata[GO_BIT] && go_wr_cnt == err_go;
    endfunction

    always @(posedge clk) begin : apb_slave
        int w;
        if (rst) begin
            m_pready  <= 1'b0;
            m_pslverr <= 1'b0;
            m_prdata  <= '0;
            go_active <= 1'b0;
            busy_cnt  <= 0;
            wait_cnt  <= 0;
            irq_q     <= 1'b0;
            ctrl_q    <= '0;
            rx_q      <= '0;
        end else begin
            if (go_active) begin
                if (busy_cnt == 0) begin
                    go_active <= 1'b0;
                    xfer_cnt  <= xfer_cnt + 1;
                    rx_q      <= (xfer_cnt == 0) ? 32'hDEAD_0000 : word_fn(cmd_addr, xfer_cnt - 1);
                    if (ctrl_q[IE_BIT]) irq_q <= 1'b1;
                end else begin
                    busy_cnt <= busy_cnt - 1;
                end
            end
            if (m_psel && !m_penable) begin
                w = $urandom_range(0, 2);
                if (w == 0) begin
                    m_pready <= 1'b1; m_prdata <= read_val(); m_pslverr <= inject();
                end else begin
                    wait_cnt <= w - 1;
                end
            end else if (m_psel && m_penable && !m_pready) begin
                if (wait_cnt == 0) begin
                    m_pready <= 1'b1; m_prdata <= read_val(); m_pslverr <= inject();
                end else begin
                    wait_cnt <= wait_cnt - 1;
                end
            end else if (m_psel && m_penable && m_pready) begin
                wr_t e;
                m_pready  <= 1'b0;
                m_pslverr <= 1'b0;
                if (m_pwrite) begin
                    e.a = m_paddr; e.d = m_pwdata;
                    wr_log.push_back(e);
                    if (m_paddr == 5'h10) begin
                        if (go_active) ctrl_busy_wr <= ctrl_busy_wr + 1;
                        if (m_pwdata[GO_BIT]) go_wr_cnt <= go_wr_cnt + 1;
                        if (!m_pslverr) begin
                            ctrl_q <= m_pwdata;
                            if (m_pwdata[GO_BIT]) begin
                                go_active <= 1'b1;
                                busy_cnt  <= $urandom_range(busy_min, busy_max);
                            end
                        end
                    end else if (!m_pslverr && m_pwdata[31:24] == 8'h03) begin
                        cmd_addr  <= m_pwdata[23:0];
                        go_wr_cnt <= 0;
                        xfer_cnt  <= 0;
                    end
                end else if (m_paddr == 5'h10) begin
                    if (go_active) ctrl_rd_busy <= ctrl_rd_busy + 1;
                    irq_q <= 1'b0;
                end
            end
        end
    end

    // APB phase ordering observer
    int proto_err = 0;
    bit prev_setup, prev_wait, prev_done;
    always @(posedge clk) begin
        if (rst) begin
            prev_setup <= 1'b0; prev_wait <= 1'b0; prev_done <= 1'b0;
        end else begin
            if ((m_penable && !m_psel) || (prev_setup && !(m_psel && m_penable)) ||
                (prev_wait && !(m_psel && m_penable)) || (prev_done && m_psel))
                proto_err <= proto_err + 1;
            prev_setup <= m_psel && !m_penable;
            prev_wait  <= m_psel && m_penable && !m_pready;
            prev_done  <= m_psel && m_penable && m_pready;
        end
    end

    // Response capture
    always @(posedge clk) begin
        rsp_t r;
        if (!rst && rsp_valid && rsp_ready) begin
            r.d = rsp_data; r.l = rsp_last; r.e = rsp_err;
            rsp_log.push_back(r);
        end
    end

    // Response back-pressure driver
    bit hold_rdy = 1'b0, rdy_rand = 1'b0;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rsp_ready = hold_rdy ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // ---------------- checking ----------------
    int checks = 0, fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 0);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, " rsp_data"}, rsp_data, 0);
        chk({tag, " rsp_last"}, 32'(rsp_last), 0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " psel"}, 32'(m_psel), 0);
        chk({tag, " penable"}, 32'(m_penable), 0);
        chk({tag, " pwrite"}, 32'(m_pwrite), 0);
        chk({tag, " paddr"}, 32'(m_paddr), 0);
        chk({tag, " pwdata"}, m_pwdata, 0);
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (req_ready) begin ok = 1'b1; return; end
        end
    endtask

    task automatic recover();
        rst = 1'b1; repeat (2) @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic start_req(input string nm, input logic [23:0] a, input int len);
        bit ok;
        wait_ready(200, ok);
        chk({nm, " accept_ready"}, 32'(ok), 1);
        req_addr = a; req_len = 8'(len); req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Expected bus writes and responses derived from the request alone
    task automatic finish_req(input string nm, input logic [23:0] a, input int len, input int egi,
                              input int wr_base, input int rsp_base, input int exp_cnt, input bit exp_err);
        bit   ok;
        int   n, stop, nrsp;
        wr_t  ew[$];
        rsp_t er[$];
        wr_t  w;
        rsp_t r;
        wait_ready(40000, ok);
        chk({nm, " back_to_idle"}, 32'(ok), 1);
        if (!ok) begin recover(); return; end
        n    = (len == 0) ? 256 : len;
        stop = (egi >= 0 && egi <= n) ? egi : -1;
        w.a = 5'h00; w.d = {8'h03, a}; ew.push_back(w);
        w.a = 5'h10; w.d = GO_WORD;    ew.push_back(w);
        if (stop != 0) begin
            for (int j = 0; j < n; j++) begin
                w.a = 5'h00; w.d = 32'hFFFF_FFFF; ew.push_back(w);
                w.a = 5'h10; w.d = GO_WORD;       ew.push_back(w);
                if (j + 1 == stop) break;
            end
        end
        w.a = 5'h10; w.d = CTRL_IDLE; ew.push_back(w);
        nrsp = (stop < 0) ? n : ((stop == 0) ? 0 : stop - 1);
        for (int i = 0; i < nrsp; i++) begin
            r.d = word_fn(a, i); r.l = (stop < 0) && (i == n - 1); r.e = 1'b0;
            er.push_back(r);
        end
        if (stop >= 0) begin r.d = 32'h0; r.l = 1'b1; r.e = 1'b1; er.push_back(r); end

        chk({nm, " rsp_count"}, 32'(rsp_log.size() - rsp_base), 32'((exp_cnt >= 0) ? exp_cnt : er.size()));
        for (int i = 0; i < er.size() && rsp_base + i < rsp_log.size(); i++) begin
            chk($sformatf("%s rsp%0d data", nm, i), rsp_log[rsp_base + i].d, er[i].d);
            chk($sformatf("%s rsp%0d last", nm, i), 32'(rsp_log[rsp_base + i].l), 32'(er[i].l));
            chk($sformatf("%s rsp%0d err", nm, i), 32'(rsp_log[rsp_base + i].e), 32'(er[i].e));
        end
        if (rsp_log.size() > rsp_base)
            chk({nm, " final_err"}, 32'(rsp_log[rsp_log.size() - 1].e), 32'(exp_err));
        chk({nm, " wr_count"}, 32'(wr_log.size() - wr_base), 32'(ew.size()));
        for (int i = 0; i < ew.size() && wr_base + i < wr_log.size(); i++) begin
            chk($sformatf("%s wr%0d addr", nm, i), 32'(wr_log[wr_base + i].a), 32'(ew[i].a));
            chk($sformatf("%s wr%0d data", nm, i), wr_log[wr_base + i].d, ew[i].d);
        end
    endtask

    task automatic run_req(input string nm, input logic [23:0] a, input int len, input int egi,
                           input int exp_cnt, input bit exp_err);
        int wb, rb;
        err_go = egi;
        wb = wr_log.size(); rb = rsp_log.size();
        start_req(nm, a, len);
        finish_req(nm, a, len, egi, wb, rb, exp_cnt, exp_err);
        err_go = -1;
    endtask

    typedef struct {
        logic [23:0] addr;
        int          len;
        int          err_go;
        bit          rdy_rand;
        int          exp_cnt;
        bit          exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int wb, rb, snap;
        bit ok;
        vecs[0] = '{24'h012345, 1, -1, 1'b0, 1, 1'b0};
        vecs[1] = '{24'hABCDEF, 3, -1, 1'b1, 3, 1'b0};
        vecs[2] = '{24'h000100, 0, -1, 1'b0, 256, 1'b0};
        vecs[3] = '{24'h0F0F0F, 4, 0, 1'b1, 1, 1'b1};
        vecs[4] = '{24'h123456, 5, 3, 1'b1, 3, 1'b1};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        @(posedge clk); #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[k]) begin
            rdy_rand = vecs[k].rdy_rand;
            run_req($sformatf("vec%0d", k), vecs[k].addr, vecs[k].len, vecs[k].err_go,
                    vecs[k].exp_cnt, vecs[k].exp_err);
        end

        // Randomized requests, occasionally with an error on one GO write
        rdy_rand = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [23:0] a;
            int len, egi;
            a   = 24'($urandom);
            len = $urandom_range(1, 6);
            egi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
            run_req($sformatf("rnd%0d", k), a, len, egi, -1, egi >= 0);
        end

        // Consumer stalls for 50 cycles while a word is being offered
        rdy_rand = 1'b0; hold_rdy = 1'b1;
        wb = wr_log.size(); rb = rsp_log.size();
        start_req("stall", 24'h054321, 2);
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
        chk("stall rsp_valid_seen", 32'(ok), 1);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("stall rsp_valid", 32'(rsp_valid), 1);
            chk("stall rsp_data", rsp_data, word_fn(24'h054321, 0));
            chk("stall psel", 32'(m_psel), 0);
            chk("stall busy", 32'(busy), 1);
        end
        chk("stall wr_count_frozen", 32'(wr_log.size() - wb), 4);
        hold_rdy = 1'b0;
        finish_req("stall", 24'h054321, 2, -1, wb, rb, 2, 1'b0);

        // Reset while waiting on a data transfer: abandoned without a DESEL write
        busy_min = 25; busy_max = 25;
        wb = wr_log.size();
        start_req("rstmid", 24'h00AA55, 2);
        ok = 1'b0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(posedge clk); #1;
            ok = (wr_log.size() - wb >= 4);
        end
        chk("rstmid reached_dat_wait", 32'(ok), 1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("rstmid");
        rst = 1'b0;
        chk("rstmid no_desel", 32'(wr_log.size() - wb), 4);
        busy_min = 0; busy_max = 2;
        run_req("after_rst", 24'h00AA55, 2, -1, 2, 1'b0);

        // Wait states: no CTRL reads while a transfer is in flight in interrupt mode, polling otherwise
        busy_min = 6; busy_max = 10;
        snap = ctrl_rd_busy;
        run_req("waitmode", 24'h3C3C3C, 2, -1, 2, 1'b0);
`ifdef SPI_RD_SEQ_IRQ_EN
        chk("irq ctrl_reads_while_busy", 32'(ctrl_rd_busy - snap), 0);
`else
        chk("poll ctrl_reads_while_busy", 32'(ctrl_rd_busy != snap), 1);
`endif
        busy_min = 0; busy_max = 2;

        repeat (5) @(posedge clk); #1;
        chk("apb_protocol_violations", 32'(proto_err), 0);
        chk("ctrl_write_while_busy", 32'(ctrl_busy_wr), 0);
        chk("end_idle_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/spi_rd_seq.md
SPI_RD_SEQ -- requirements
Module: spi_rd_seq

Interface
REQ-001 Parameter CTRL_SEL, default 32'h0000_0000: control word holding the chip-select bit, ASS=0, LSB=0 and divider fields; CHAR_LEN and GO bits are zero.
REQ-002 Parameter CTRL_IDLE, default 32'h0000_0000: control word written at transaction end, with chip-select cleared.
REQ-003 Parameter GO_BIT, default 8: bit index of GO in the SPI control word.
REQ-004 clk  in  1  sole clock; same clock as the PCLK of the downstream SPI controller.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 req_valid/req_ready  in/out  1/1  read-request handshake.
REQ-007 req_addr  in  24  flash byte address.
REQ-008 req_len  in  8  words to read; 0 means 256.
REQ-009 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-010 rsp_data  out  32  received word, passed through unswapped.
REQ-011 rsp_last  out  1  marks the final word of a request.
REQ-012 rsp_err  out  1  marks a response terminated by an APB error.
REQ-013 busy  out  1  high whenever the block is not IDLE.
REQ-014 m_paddr  out  5  APB master address.
REQ-015 m_pwdata  out  32  APB write data.
REQ-016 m_psel, m_penable, m_pwrite  out  1  APB master controls.
REQ-017 m_prdata  in  32  APB read data.
REQ-018 m_pready, m_pslverr  in  1  APB completion and error.
REQ-019 irq_i  in  1  SPI controller interrupt.

Function
REQ-020 Register byte offsets SHALL be: RX0/TX0 = 0x00, CTRL = 0x10.
REQ-021 Every APB access SHALL take one SETUP cycle (psel=1, penable=0), then ACCESS (psel=1, penable=1) held until pready=1; psel and penable SHALL drop in the cycle after completion.
REQ-022 The FSM SHALL use these states: IDLE, CMD_TX, CMD_GO, CMD_WAIT, DAT_TX, DAT_GO, DAT_WAIT, DAT_RX, PUSH, DESEL.
REQ-023 In IDLE, req_ready=1; on acceptance the block SHALL latch addr and len and go to CMD_TX.
REQ-024 CMD_TX SHALL write TX0 = {8'h03, req_addr}.
REQ-025 CMD_GO SHALL write CTRL = CTRL_SEL | (1<<GO_BIT) | 32.
REQ-026 Each *_WAIT state SHALL read CTRL repeatedly until bit GO_BIT reads 0.
REQ-027 DAT_TX SHALL write TX0 = 32'hFFFF_FFFF; DAT_GO and DAT_WAIT SHALL behave as CMD_GO and CMD_WAIT.
REQ-028 DAT_RX SHALL read RX0, latch the result into rsp_data, and go to PUSH.
REQ-029 PUSH SHALL hold rsp_valid=1 with stable data until rsp_ready.
REQ-030 After a PUSH handshake: if the remaining count is nonzero, go to DAT_TX; else go to DESEL.
REQ-031 DESEL SHALL write CTRL = CTRL_IDLE, then go to IDLE; rsp_last=1 accompanies the final word.
REQ-032 CTRL writes SHALL occur only after GO has read 0, so the controller never sees a write while a transfer is in progress.
REQ-033 Error handling: if m_pslverr=1 on any completion:
  - go directly to PUSH with rsp_err=1, rsp_last=1, rsp_data=0;
  - then go to DESEL.
REQ-034 The remaining-word counter SHALL be 9 bits wide, loaded with req_len or 256, and decremented at each PUSH handshake.

Reset
REQ-035 On rst=1 at a clk edge, the following SHALL all be 0 and the FSM SHALL be IDLE: req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, busy, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata.
REQ-036 Reset mid-transaction SHALL abandon the access with no DESEL write; chip-select recovery is the SPI controller's own reset.

Configuration
REQ-037 With SPI_RD_SEQ_IRQ_EN defined:
  - CMD_GO and DAT_GO SHALL additionally set the IE bit (parameter IE_BIT, default 12);
  - the *_WAIT states SHALL issue no APB access and SHALL wait for irq_i=1;
  - then one dummy CTRL read SHALL clear the interrupt.
REQ-038 Without SPI_RD_SEQ_IRQ_EN, irq_i SHALL be ignored and the *_WAIT states SHALL poll as in REQ-026.

Structure
REQ-039 A shared package spi_seq_pkg SHALL hold:
  - the register offsets;
  - the flash opcode 8'h03;
  - the FSM state enumeration.
REQ-040 One sub-module, spi_apb_mst, SHALL implement the single-access APB master.
  - Inputs: start, addr, wdata, write.
  - Outputs: done, rdata, err.
  - The FSM SHALL sequence it.

Verification
REQ-041 req addr=0x012345, len=1 against the spi_top model:
  - TX0 writes 0x03012345 then 0xFFFFFFFF;
  - the slave returns 0xA5A5_5A5A;
  - exactly one rsp with rsp_last=1 and data 0xA5A55A5A;
  - CTRL_IDLE is written last.
REQ-042 len=0 -> exactly 256 responses; rsp_last=1 only on the 256th.
REQ-043 rsp_ready held 0 for 50 cycles during PUSH -> rsp_valid and rsp_data stable, no APB activity, busy=1.
REQ-044 m_pslverr=1 on the CMD_GO write -> single rsp with rsp_err=1, rsp_last=1, data 0; DESEL write follows; returns to IDLE.
REQ-045 rst asserted in DAT_WAIT -> next cycle all outputs 0 and IDLE; a new request then completes normally.
REQ-046 With SPI_RD_SEQ_IRQ_EN defined, len=2 -> no CTRL reads between GO and irq_i; 2 responses, correct data.
